// File: rtl/circ_ptr_tracker.sv
// -----------------------------------------------------------------------------
// circ_ptr_tracker
//
// Registered head/tail/occupancy tracker for a circular buffer of SIZE slots.
// SIZE does not have to be a power of two. Each cycle the tail can advance by
// up to MAX_OPS slots (push) and the head can advance by up to MAX_OPS slots
// (pop), wrapping modulo SIZE. flush discards every entry.
//
// Per-cycle priority is flush > pop > push. A request that cannot be honoured
// in full is dropped in full; a partial push or pop never happens. Slots freed
// by a pop in the same cycle can be used by a push in that cycle.
//
// Optional feature, selected by the CIRC_PTR_ERR_EN macro:
//   defined   : err is a sticky register. It is set by any dropped push or pop
//               in a cycle without flush, and only reset clears it.
//   undefined : err is tied to 0. Illegal requests are still dropped.
//
// Parameters
//   SIZE     number of slots (>= 2)
//   MAX_OPS  largest push or pop amount per cycle (1..SIZE)
//   NBITS    pointer width, clog2(SIZE)          (derived)
//   OPW      push/pop amount width, clog2(MAX_OPS+1) (derived)
//   CW       count width, clog2(SIZE+1)          (derived)
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-high reset
//   push_num  slots to allocate at the tail this cycle (0 = none)
//   pop_num   slots to retire at the head this cycle (0 = none)
//   flush     discard all entries (tail <= head, count <= 0)
//   head      index of the oldest valid slot
//   tail      index of the next slot to allocate
//   count     number of valid entries, 0..SIZE
//   free_cnt  SIZE - count
//   full      count == SIZE
//   empty     count == 0
//   err       sticky illegal-request flag (0 unless CIRC_PTR_ERR_EN)
//
// Every output comes from a register or a decode of registers. No input
// reaches an output combinationally.
// -----------------------------------------------------------------------------
module circ_ptr_tracker #(
  parameter  int SIZE    = 4,
  parameter  int MAX_OPS = 2,
  localparam int NBITS   = $clog2(SIZE),
  localparam int OPW     = $clog2(MAX_OPS + 1),
  localparam int CW      = $clog2(SIZE + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPW-1:0]   push_num,
  input  logic [OPW-1:0]   pop_num,
  input  logic             flush,
  output logic [NBITS-1:0] head,
  output logic [NBITS-1:0] tail,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    free_cnt,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam logic [NBITS:0]  SIZE_P  = (NBITS + 1)'(SIZE);
  localparam logic [CW-1:0]   SIZE_C  = CW'(SIZE);
  localparam logic [OPW-1:0]  MAX_OPN = OPW'(MAX_OPS);

  // The sum is formed one bit wider than a pointer. n <= MAX_OPS <= SIZE, so
  // one conditional subtraction of SIZE is enough to bring it back in range.
  function automatic logic [NBITS-1:0] adv(input logic [NBITS-1:0] p,
                                           input logic [OPW-1:0]   n);
    logic [NBITS:0] sum;
    sum = {1'b0, p} + (NBITS + 1)'(n);
    if (sum >= SIZE_P) sum = sum - SIZE_P;
    return sum[NBITS-1:0];
  endfunction

  logic           pop_ok;
  logic           push_ok;
  logic [CW:0]    push_room;
  logic [OPW-1:0] acc_pop;
  logic [OPW-1:0] acc_push;
  logic [CW-1:0]  count_nxt;

  assign free_cnt = SIZE_C - count;
  assign full     = (count == SIZE_C);
  assign empty    = (count == '0);

  // NOTE: each signal assigned in always_comb gets a default at the top of the
  // block. A path that leaves a signal unassigned would infer a latch.
  always_comb begin
    pop_ok    = 1'b0;
    push_ok   = 1'b0;
    push_room = '0;
    acc_pop   = '0;
    acc_push  = '0;
    count_nxt = count;

    pop_ok  = (pop_num <= MAX_OPN) && (CW'(pop_num) <= count);
    acc_pop = pop_ok ? pop_num : '0;

    // An accepted pop in the same cycle frees space the push may use.
    push_room = {1'b0, free_cnt} + (CW + 1)'(acc_pop);
    push_ok   = (push_num <= MAX_OPN) && ((CW + 1)'(push_num) <= push_room);
    acc_push  = push_ok ? push_num : '0;

    count_nxt = count + CW'(acc_push) - CW'(acc_pop);
  end

  // NOTE: sequential state is updated only with non-blocking assignments, so
  // every register samples the values that held before the clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      tail  <= head;
      count <= '0;
    end else begin
      // A dropped request has an accepted amount of 0, so adv() leaves that
      // pointer where it is.
      head  <= adv(head, acc_pop);
      tail  <= adv(tail, acc_push);
      count <= count_nxt;
    end
  end

`ifdef CIRC_PTR_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (!flush && (!pop_ok || !push_ok)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
